// File: rtl/clk_enable_dds.sv
// Multi-channel phase-accumulator clock-enable generator: each channel emits a one-cycle
// strobe on accumulator carry, with runtime retune (applied at a period boundary), pause and turbo.
module clk_enable_dds #(
    parameter int          CHANNELS  = 4,
    parameter int          ACC_W     = 32,
    parameter logic [31:0] INC_RESET = 32'h11EB851F,
    parameter int          SEL_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                  clkin,
    input  logic                  RESET_N,
    input  logic                  inc_wr,
    input  logic [SEL_W-1:0]      inc_sel,
    input  logic [ACC_W-1:0]      inc_data,
    output logic                  inc_busy,
    input  logic [CHANNELS-1:0]   pause,
    input  logic [2*CHANNELS-1:0] turbo,
    output logic [CHANNELS-1:0]   ce,
    output logic [CHANNELS-1:0]   phase
);

    localparam logic [ACC_W-1:0] INC_INIT = INC_RESET[ACC_W-1:0];

    typedef enum logic [1:0] {
        IDLE,
        PENDING,
        APPLIED
    } wrState_e;

    wrState_e            state_q, state_d;
    logic [SEL_W-1:0]    pendSel_q, pendSel_d;
    logic [ACC_W-1:0]    pendData_q, pendData_d;

    logic [ACC_W-1:0]    acc_q [CHANNELS];
    logic [ACC_W-1:0]    acc_d [CHANNELS];
    logic [ACC_W-1:0]    inc_q [CHANNELS];
    logic [ACC_W-1:0]    inc_d [CHANNELS];
    logic [CHANNELS-1:0] ce_q, ce_d;
    logic [CHANNELS-1:0] phase_q, phase_d;

    logic [ACC_W+2:0]    shifted [CHANNELS];
    logic [ACC_W-1:0]    effInc  [CHANNELS];
    logic [ACC_W:0]      sum     [CHANNELS];
    logic                selOk;

    assign selOk    = (32'(inc_sel) < 32'(CHANNELS));
    assign inc_busy = (state_q != IDLE);
    assign ce       = ce_q;
    assign phase    = phase_q;

    // Turbo shifts the increment left; any bit pushed past the MSB saturates to all ones.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            shifted[i] = {3'b000, inc_q[i]} << turbo[2*i +: 2];
            effInc[i]  = (|shifted[i][ACC_W+2:ACC_W]) ? {ACC_W{1'b1}} : shifted[i][ACC_W-1:0];
            sum[i]     = {1'b0, acc_q[i]} + {1'b0, effInc[i]};
            acc_d[i]   = acc_q[i];
            ce_d[i]    = 1'b0;
            phase_d[i] = phase_q[i];
            if (!pause[i]) begin
                acc_d[i]   = sum[i][ACC_W-1:0];
                ce_d[i]    = sum[i][ACC_W];
                phase_d[i] = sum[i][ACC_W-1];
            end
        end
    end

    // A pending increment lands on the carrying edge so the current period finishes at the old rate;
    // a stopped or paused target has no period to finish, so it is loaded straight away.
    always_comb begin
        state_d    = state_q;
        pendSel_d  = pendSel_q;
        pendData_d = pendData_q;
        inc_d      = inc_q;
        case (state_q)
            IDLE: begin
                if (inc_wr && selOk) begin
                    pendSel_d  = inc_sel;
                    pendData_d = inc_data;
                    state_d    = PENDING;
                end
            end
            PENDING: begin
                if (ce_d[pendSel_q] || pause[pendSel_q] || (inc_q[pendSel_q] == '0)) begin
                    inc_d[pendSel_q] = pendData_q;
                    state_d          = APPLIED;
                end
            end
            APPLIED: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clkin or negedge RESET_N) begin
        if (!RESET_N) begin
            acc_q      <= '{default: '0};
            inc_q      <= '{default: INC_INIT};
            ce_q       <= '0;
            phase_q    <= '0;
            state_q    <= IDLE;
            pendSel_q  <= '0;
            pendData_q <= '0;
        end else begin
            acc_q      <= acc_d;
            inc_q      <= inc_d;
            ce_q       <= ce_d;
            phase_q    <= phase_d;
            state_q    <= state_d;
            pendSel_q  <= pendSel_d;
            pendData_q <= pendData_d;
        end
    end

endmodule

// File: tb/tb_clk_enable_dds.sv
// Bench for clk_enable_dds: an 8-bit, 3-channel instance for timing scenarios and a
// default-parameter instance for long-run rate accuracy.
module tb_clk_enable_dds;

    logic clkin = 1'b0;
    always #5 clkin = ~clkin;

    logic       RESET_N = 1'b0;
    logic       inc_wr;
    logic [1:0] inc_sel;
    logic [7:0] inc_data;
    logic       inc_busy;
    logic [2:0] pause;
    logic [5:0] turbo;
    logic [2:0] ce;
    logic [2:0] phase;

    logic        dWr    = 1'b0;
    logic [1:0]  dSel   = 2'd0;
    logic [31:0] dData  = 32'd0;
    logic        dBusy;
    logic [3:0]  dPause = 4'd0;
    logic [7:0]  dTurbo = 8'd0;
    logic [3:0]  dCe;
    logic [3:0]  dPhase;

    int total = 0;
    int bad = 0;
    int edgeNo = 0;
    int mAcc = 0;
    int expQ[$];

    // INC_RESET 0x140 truncates to 64 at ACC_W=8.
    clk_enable_dds #(.CHANNELS(3), .ACC_W(8), .INC_RESET(32'h0000_0140)) dut (
        .clkin(clkin), .RESET_N(RESET_N), .inc_wr(inc_wr), .inc_sel(inc_sel),
        .inc_data(inc_data), .inc_busy(inc_busy), .pause(pause), .turbo(turbo),
        .ce(ce), .phase(phase)
    );

    clk_enable_dds dutDefault (
        .clkin(clkin), .RESET_N(RESET_N), .inc_wr(dWr), .inc_sel(dSel),
        .inc_data(dData), .inc_busy(dBusy), .pause(dPause), .turbo(dTurbo),
        .ce(dCe), .phase(dPhase)
    );

    task automatic nextEdge();
        @(posedge clkin);
        #1;
        edgeNo++;
    endtask

    task automatic applyReset();
        inc_wr = 1'b0; inc_sel = 2'd0; inc_data = 8'd0; pause = 3'd0; turbo = 6'd0;
        @(posedge clkin);
        #1 RESET_N = 1'b0;
        @(posedge clkin);
        #1 RESET_N = 1'b1;
        edgeNo = 0;
        mAcc = 0;
        expQ.delete();
    endtask

    task automatic test_reset();
        inc_wr = 1'b0; inc_sel = 2'd0; inc_data = 8'd0; pause = 3'd0; turbo = 6'd0;
        RESET_N = 1'b0;
        #12;
        total++;
        if ({ce, phase, inc_busy} !== 7'd0) begin
            bad++; $display("[TB] FAIL reset_small: ce/phase/busy=%b required 0", {ce, phase, inc_busy});
        end
        total++;
        if ({dCe, dPhase, dBusy} !== 9'd0) begin
            bad++; $display("[TB] FAIL reset_default: ce/phase/busy=%b required 0", {dCe, dPhase, dBusy});
        end
        @(posedge clkin);
        #1 RESET_N = 1'b1;
        edgeNo = 0;
        nextEdge();
        total++;
        if ({ce, phase, inc_busy} !== 7'd0) begin
            bad++; $display("[TB] FAIL reset_edge1: ce/phase/busy=%b required 0", {ce, phase, inc_busy});
        end
    endtask

    task automatic test_default_rate();
        int ceCnt0 = 0, ceCnt1 = 0, toggles = 0;
        logic prevPhase;
        applyReset();
        prevPhase = dPhase[0];
        for (int k = 0; k < 50000; k++) begin
            nextEdge();
            ceCnt0 += int'(dCe[0]);
            ceCnt1 += int'(dCe[1]);
            if (dPhase[0] !== prevPhase) toggles++;
            prevPhase = dPhase[0];
        end
        total++;
        if (ceCnt0 < 3499 || ceCnt0 > 3501) begin
            bad++; $display("[TB] FAIL rate_ce0: count %0d required 3500+/-1", ceCnt0);
        end
        total++;
        if (ceCnt1 < 3499 || ceCnt1 > 3501) begin
            bad++; $display("[TB] FAIL rate_ce1: count %0d required 3500+/-1", ceCnt1);
        end
        total++;
        if (toggles < 6998 || toggles > 7002) begin
            bad++; $display("[TB] FAIL rate_phase: toggles %0d required 7000+/-2", toggles);
        end
    endtask

    task automatic test_basic();
        int exp;
        applyReset();
        for (int k = 4; k <= 40; k += 4) expQ.push_back(k);
        for (int k = 0; k < 40; k++) begin
            nextEdge();
            mAcc = (mAcc + 64) % 256;
            total++;
            if (phase[0] !== logic'(mAcc >= 128)) begin
                bad++; $display("[TB] FAIL basic_phase: edge %0d phase %b required %b", edgeNo, phase[0], mAcc >= 128);
            end
            if (ce[0] === 1'b1) begin
                total++;
                if (expQ.size() == 0) begin
                    bad++; $display("[TB] FAIL basic_ce: strobe at edge %0d, none required", edgeNo);
                end else begin
                    exp = expQ.pop_front();
                    if (edgeNo !== exp) begin
                        bad++; $display("[TB] FAIL basic_ce: strobe at edge %0d, required edge %0d", edgeNo, exp);
                    end
                end
            end
        end
        total++;
        if (expQ.size() != 0) begin
            bad++; $display("[TB] FAIL basic_drain: %0d strobes missing, required 0", expQ.size());
        end
    endtask

    task automatic test_pause();
        int exp;
        logic paused;
        applyReset();
        expQ.push_back(4); expQ.push_back(18); expQ.push_back(22);
        for (int k = 0; k < 24; k++) begin
            paused   = (edgeNo + 1 >= 7) && (edgeNo + 1 <= 16);
            pause[0] = paused;
            nextEdge();
            if (!paused) mAcc = (mAcc + 64) % 256;
            total++;
            if (phase[0] !== logic'(mAcc >= 128)) begin
                bad++; $display("[TB] FAIL pause_phase: edge %0d phase %b required %b", edgeNo, phase[0], mAcc >= 128);
            end
            if (ce[0] === 1'b1) begin
                total++;
                if (expQ.size() == 0) begin
                    bad++; $display("[TB] FAIL pause_ce: strobe at edge %0d, none required", edgeNo);
                end else begin
                    exp = expQ.pop_front();
                    if (edgeNo !== exp) begin
                        bad++; $display("[TB] FAIL pause_ce: strobe at edge %0d, required edge %0d", edgeNo, exp);
                    end
                end
            end
        end
        pause = 3'd0;
        total++;
        if (expQ.size() != 0) begin
            bad++; $display("[TB] FAIL pause_drain: %0d strobes missing, required 0", expQ.size());
        end
    endtask

    task automatic test_turbo();
        int exp;
        int eff;
        int span;
        for (int t = 2; t >= 1; t--) begin
            applyReset();
            turbo[1:0] = 2'(t);
            eff  = (t == 2) ? 255 : 128;
            span = (t == 2) ? 256 : 20;
            if (t == 2) for (int k = 2; k <= 256; k++) expQ.push_back(k);
            else        for (int k = 2; k <= 20; k += 2) expQ.push_back(k);
            for (int k = 0; k < span; k++) begin
                nextEdge();
                mAcc = (mAcc + eff) % 256;
                total++;
                if (phase[0] !== logic'(mAcc >= 128)) begin
                    bad++; $display("[TB] FAIL turbo%0d_phase: edge %0d phase %b required %b", t, edgeNo, phase[0], mAcc >= 128);
                end
                if (ce[0] === 1'b1) begin
                    total++;
                    if (expQ.size() == 0) begin
                        bad++; $display("[TB] FAIL turbo%0d_ce: strobe at edge %0d, none required", t, edgeNo);
                    end else begin
                        exp = expQ.pop_front();
                        if (edgeNo !== exp) begin
                            bad++; $display("[TB] FAIL turbo%0d_ce: strobe at edge %0d, required edge %0d", t, edgeNo, exp);
                        end
                    end
                end
            end
            total++;
            if (expQ.size() != 0) begin
                bad++; $display("[TB] FAIL turbo%0d_drain: %0d strobes missing, required 0", t, expQ.size());
            end
        end
        turbo = 6'd0;
    endtask

    task automatic test_write();
        int exp;
        int mInc = 64;
        logic expBusy;
        applyReset();
        expQ.push_back(4); expQ.push_back(12); expQ.push_back(20); expQ.push_back(28);
        for (int k = 0; k < 30; k++) begin
            nextEdge();
            mAcc = (mAcc + mInc) % 256;
            if (edgeNo == 4) mInc = 32;
            expBusy = (edgeNo == 3) || (edgeNo == 4);
            total++;
            if (inc_busy !== expBusy) begin
                bad++; $display("[TB] FAIL write_busy: edge %0d busy %b required %b", edgeNo, inc_busy, expBusy);
            end
            total++;
            if (phase[0] !== logic'(mAcc >= 128)) begin
                bad++; $display("[TB] FAIL write_phase: edge %0d phase %b required %b", edgeNo, phase[0], mAcc >= 128);
            end
            if (ce[0] === 1'b1) begin
                total++;
                if (expQ.size() == 0) begin
                    bad++; $display("[TB] FAIL write_ce: strobe at edge %0d, none required", edgeNo);
                end else begin
                    exp = expQ.pop_front();
                    if (edgeNo !== exp) begin
                        bad++; $display("[TB] FAIL write_ce: strobe at edge %0d, required edge %0d", edgeNo, exp);
                    end
                end
            end
            case (edgeNo)
                2: begin inc_wr = 1'b1; inc_sel = 2'd0; inc_data = 8'd32; end
                3: begin inc_wr = 1'b1; inc_sel = 2'd0; inc_data = 8'd8;  end
                5: begin inc_wr = 1'b1; inc_sel = 2'd3; inc_data = 8'd8;  end
                default: begin inc_wr = 1'b0; inc_sel = 2'd0; inc_data = 8'd0; end
            endcase
        end
        total++;
        if (expQ.size() != 0) begin
            bad++; $display("[TB] FAIL write_drain: %0d strobes missing, required 0", expQ.size());
        end
    endtask

    task automatic test_reset_pending();
        int exp;
        applyReset();
        nextEdge();
        inc_wr = 1'b1; inc_sel = 2'd0; inc_data = 8'd16;
        nextEdge();
        inc_wr = 1'b0; inc_data = 8'd0;
        total++;
        if (inc_busy !== 1'b1) begin
            bad++; $display("[TB] FAIL rstpend_busy_before: busy %b required 1", inc_busy);
        end
        RESET_N = 1'b0;
        #1;
        total++;
        if ({ce[0], phase[0], inc_busy} !== 3'b000) begin
            bad++; $display("[TB] FAIL rstpend_in_reset: ce/phase/busy=%b required 000", {ce[0], phase[0], inc_busy});
        end
        @(posedge clkin);
        #1 RESET_N = 1'b1;
        edgeNo = 0;
        mAcc = 0;
        for (int k = 4; k <= 16; k += 4) expQ.push_back(k);
        for (int k = 0; k < 16; k++) begin
            nextEdge();
            mAcc = (mAcc + 64) % 256;
            total++;
            if (inc_busy !== 1'b0) begin
                bad++; $display("[TB] FAIL rstpend_busy: edge %0d busy %b required 0", edgeNo, inc_busy);
            end
            total++;
            if (phase[0] !== logic'(mAcc >= 128)) begin
                bad++; $display("[TB] FAIL rstpend_phase: edge %0d phase %b required %b", edgeNo, phase[0], mAcc >= 128);
            end
            if (ce[0] === 1'b1) begin
                total++;
                if (expQ.size() == 0) begin
                    bad++; $display("[TB] FAIL rstpend_ce: strobe at edge %0d, none required", edgeNo);
                end else begin
                    exp = expQ.pop_front();
                    if (edgeNo !== exp) begin
                        bad++; $display("[TB] FAIL rstpend_ce: strobe at edge %0d, required edge %0d", edgeNo, exp);
                    end
                end
            end
        end
        total++;
        if (expQ.size() != 0) begin
            bad++; $display("[TB] FAIL rstpend_drain: %0d strobes missing, required 0", expQ.size());
        end
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_default_rate();
        test_basic();
        test_pause();
        test_turbo();
        test_write();
        test_reset_pending();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
